// File: rtl/game_round_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the round controller and the sprite pixel generator.
// Holds the game/missile state encodings, screen geometry, sprite sizes and a
// small saturating-increment helper used for the score.
// ---------------------------------------------------------------------------
package game_pkg;

  // Round-level state of the game
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_e;

  // Missile sub-state
  typedef enum logic {
    M_IDLE = 1'b0,
    M_FLY  = 1'b1
  } missile_state_e;

  // Screen geometry
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned FRAME_V  = 480;

  // Sprite sizes and the missile's vertical offset from the dragon's top edge
  localparam int unsigned SPR_W    = 40;
  localparam int unsigned M_W      = 56;
  localparam int unsigned M_Y_OFS  = 9;

  // Right-most legal missile x position (left edge); beyond this it is off-screen
  localparam int unsigned M_X_MAX  = SCREEN_W - M_W;

  // Score counter stops at its maximum instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_round_ctrl_if
// Bundles the signals between the round controller and the rest of the game
// (VGA counters, buttons, dragon position, collision code, sprite controls).
//   master : the round controller (consumes counters/buttons/Event, drives
//            missile position, valid flags, score, lives, game_over)
//   slave  : the pixel generator / board side (the mirror image)
// ---------------------------------------------------------------------------
interface game_round_ctrl_if;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       start;
  logic       fire;
  logic [9:0] d_x;
  logic [9:0] d_y;
  logic [1:0] Event;
  logic [9:0] m_x;
  logic [9:0] m_y;
  logic       m_valid;
  logic       d_valid;
  logic       r_valid;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  modport master (
    input  h_cnt, v_cnt, start, fire, d_x, d_y, Event,
    output m_x, m_y, m_valid, d_valid, r_valid, score, lives, game_over
  );

  modport slave (
    output h_cnt, v_cnt, start, fire, d_x, d_y, Event,
    input  m_x, m_y, m_valid, d_valid, r_valid, score, lives, game_over
  );

endinterface

// File: rtl/game_round_ctrl_frame_tick_gen.sv
// ---------------------------------------------------------------------------
// frame_tick_gen
// Produces a single-cycle pulse once per frame, at the first pixel of the
// line where the vertical counter reaches FRAME_V (start of vertical blank).
// Ports:
//   h_cnt, v_cnt : VGA horizontal / vertical counters
//   tick         : frame tick, high for one pixel clock per frame
// ---------------------------------------------------------------------------
module frame_tick_gen
  import game_pkg::*;
(
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  output logic       tick
);

  assign tick = (h_cnt == 10'd0) && (v_cnt == 10'(FRAME_V));

endmodule

// File: rtl/game_round_ctrl.sv
// ---------------------------------------------------------------------------
// game_round_ctrl
// Sequences one round of play for the sprite pixel generator: owns the
// missile position, the dragon/robot/missile valid flags, the score and the
// lives counter. Positions and visibility only change on the frame tick or
// on a collision/button event, and every output comes straight from a flop.
// Ports:
//   clk_25Hz : pixel clock
//   rst      : asynchronous, active-low reset
//   bus      : game_round_ctrl_if.master (counters, buttons, dragon position,
//              collision code in; missile position, valid flags, score,
//              lives, game_over out)
// ---------------------------------------------------------------------------
module game_round_ctrl
  import game_pkg::*;
#(
  parameter logic [1:0]  LIVES       = 2'd3,
  parameter int unsigned MSPEED      = 4,
  parameter int unsigned HIT_FRAMES  = 64,
  parameter int unsigned RESP_FRAMES = 32,
  parameter int unsigned BLINK_SH    = 3
) (
  input  logic               clk_25Hz,
  input  logic               rst,
  game_round_ctrl_if.master  bus
);

  localparam int unsigned FRAME_W = $clog2(HIT_FRAMES + 1);
  localparam int unsigned RESP_W  = $clog2(RESP_FRAMES + 1);

  game_state_e          state_q,     state_d;
  missile_state_e       m_state_q,   m_state_d;
  logic [9:0]           m_x_q,       m_x_d;
  logic [9:0]           m_y_q,       m_y_d;
  logic                 m_valid_q,   m_valid_d;
  logic                 d_valid_q,   d_valid_d;
  logic                 r_valid_q,   r_valid_d;
  logic [7:0]           score_q,     score_d;
  logic [1:0]           lives_q,     lives_d;
  logic                 game_over_q, game_over_d;
  logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [RESP_W-1:0]    resp_cnt_q,  resp_cnt_d;
  logic [1:0]           ev_q,        ev_d;

  logic                 tick;
  logic                 new_ev;
  logic [10:0]          m_x_adv;
  logic [10:0]          launch_x;
  logic                 launch_ok;
  logic [FRAME_W-1:0]   frame_inc;

  frame_tick_gen u_tick (
    .h_cnt (bus.h_cnt),
    .v_cnt (bus.v_cnt),
    .tick  (tick)
  );

  // A held collision code must only count once, so only a change to a
  // non-zero code is treated as a new event (this also catches 01 -> 11).
  assign new_ev = (bus.Event != 2'b00) && (bus.Event != ev_q);

  // Widened by one bit so positions near the right edge cannot wrap
  assign m_x_adv   = {1'b0, m_x_q} + 11'(MSPEED);
  assign launch_x  = {1'b0, bus.d_x} + 11'(SPR_W);
  assign launch_ok = (launch_x <= 11'(M_X_MAX));
  assign frame_inc = frame_cnt_q + FRAME_W'(1);

  always_comb begin
    state_d     = state_q;
    m_state_d   = m_state_q;
    m_x_d       = m_x_q;
    m_y_d       = m_y_q;
    m_valid_d   = m_valid_q;
    d_valid_d   = d_valid_q;
    r_valid_d   = r_valid_q;
    score_d     = score_q;
    lives_d     = lives_q;
    game_over_d = game_over_q;
    frame_cnt_d = frame_cnt_q;
    resp_cnt_d  = resp_cnt_q;
    ev_d        = bus.Event;

    // Robot respawn timer runs in every state while the robot is hidden
    if (!r_valid_q && tick) begin
      if (resp_cnt_q == RESP_W'(RESP_FRAMES - 1)) begin
        r_valid_d  = 1'b1;
        resp_cnt_d = '0;
      end else begin
        resp_cnt_d = resp_cnt_q + RESP_W'(1);
      end
    end

    // Missile flight; a collision below overrides this by retiring in place
    if (m_state_q == M_FLY && tick) begin
      if (m_x_adv > 11'(M_X_MAX)) begin
        m_valid_d = 1'b0;
        m_state_d = M_IDLE;
      end else begin
        m_x_d = m_x_adv[9:0];
      end
    end

    case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          state_d     = PLAY;
          score_d     = '0;
          lives_d     = LIVES;
          d_valid_d   = 1'b1;
          r_valid_d   = 1'b1;
          m_valid_d   = 1'b0;
          m_state_d   = M_IDLE;
          m_x_d       = m_x_q;
          game_over_d = 1'b0;
          frame_cnt_d = '0;
          resp_cnt_d  = '0;
        end
      end

      PLAY: begin
        if (new_ev) begin
          m_valid_d = 1'b0;
          m_state_d = M_IDLE;
          m_x_d     = m_x_q;
          if (bus.Event[1]) begin
            if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
            state_d     = HIT;
            frame_cnt_d = '0;
          end else begin
            score_d    = sat_inc8(score_q);
            r_valid_d  = 1'b0;
            resp_cnt_d = '0;
          end
        end else if (bus.fire && m_state_q == M_IDLE && launch_ok) begin
          m_x_d     = launch_x[9:0];
          m_y_d     = bus.d_y + 10'(M_Y_OFS);
          m_valid_d = 1'b1;
          m_state_d = M_FLY;
        end
      end

      HIT: begin
        if (tick) begin
          if (frame_cnt_q == FRAME_W'(HIT_FRAMES - 1)) begin
            frame_cnt_d = '0;
            if (lives_q == 2'd0) begin
              state_d     = OVER;
              d_valid_d   = 1'b0;
              game_over_d = 1'b1;
            end else begin
              state_d   = PLAY;
              d_valid_d = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_inc;
            d_valid_d   = ~frame_inc[BLINK_SH];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Single register bank for both FSMs and all datapath state
  always_ff @(posedge clk_25Hz or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      m_state_q   <= M_IDLE;
      m_x_q       <= '0;
      m_y_q       <= '0;
      m_valid_q   <= 1'b0;
      d_valid_q   <= 1'b1;
      r_valid_q   <= 1'b1;
      score_q     <= '0;
      lives_q     <= LIVES;
      game_over_q <= 1'b0;
      frame_cnt_q <= '0;
      resp_cnt_q  <= '0;
      ev_q        <= '0;
    end else begin
      state_q     <= state_d;
      m_state_q   <= m_state_d;
      m_x_q       <= m_x_d;
      m_y_q       <= m_y_d;
      m_valid_q   <= m_valid_d;
      d_valid_q   <= d_valid_d;
      r_valid_q   <= r_valid_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      frame_cnt_q <= frame_cnt_d;
      resp_cnt_q  <= resp_cnt_d;
      ev_q        <= ev_d;
    end
  end

  assign bus.m_x       = m_x_q;
  assign bus.m_y       = m_y_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.r_valid   = r_valid_q;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_round_ctrl
// Directed bench for game_round_ctrl. Drives the VGA counters directly so a
// frame tick can be produced in any chosen cycle, and compares the outputs
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_game_round_ctrl;

  logic clk_25Hz = 1'b0;
  logic rst      = 1'b0;

  int n_vectors     = 0;
  int n_miscompares = 0;

  game_round_ctrl_if bus ();

  game_round_ctrl dut (
    .clk_25Hz (clk_25Hz),
    .rst      (rst),
    .bus      (bus)
  );

  always #20 clk_25Hz = ~clk_25Hz;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one clock cycle of inputs; pulses drop after the edge, Event is held
  task automatic applyStimulus(input logic s, input logic f, input logic t, input logic [1:0] e);
    bus.start = s;
    bus.fire  = f;
    bus.Event = e;
    bus.h_cnt = t ? 10'd0   : 10'd5;
    bus.v_cnt = t ? 10'd480 : 10'd0;
    @(posedge clk_25Hz);
    #1;
    bus.start = 1'b0;
    bus.fire  = 1'b0;
    bus.h_cnt = 10'd5;
    bus.v_cnt = 10'd0;
  endtask

  task automatic ticks(input int n, input logic [1:0] e);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, e);
  endtask

  task automatic idles(input int n, input logic [1:0] e);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".m_x"},       32'(bus.m_x),       32'd0);
    checkOutput({tag, ".m_y"},       32'(bus.m_y),       32'd0);
    checkOutput({tag, ".m_valid"},   32'(bus.m_valid),   32'd0);
    checkOutput({tag, ".d_valid"},   32'(bus.d_valid),   32'd1);
    checkOutput({tag, ".r_valid"},   32'(bus.r_valid),   32'd1);
    checkOutput({tag, ".score"},     32'(bus.score),     32'd0);
    checkOutput({tag, ".lives"},     32'(bus.lives),     32'd3);
    checkOutput({tag, ".game_over"}, 32'(bus.game_over), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.fire  = 1'b0;
    bus.Event = 2'b00;
    bus.h_cnt = 10'd5;
    bus.v_cnt = 10'd0;
    bus.d_x   = 10'd100;
    bus.d_y   = 10'd200;

    // Reset state
    #55;
    checkReset("reset");
    #10 rst = 1'b1;
    @(posedge clk_25Hz);
    #1;

    // Start the round, then launch from the dragon
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("start.lives", 32'(bus.lives), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    checkOutput("launch.m_x",     32'(bus.m_x),     32'd140);
    checkOutput("launch.m_y",     32'(bus.m_y),     32'd209);
    checkOutput("launch.m_valid", 32'(bus.m_valid), 32'd1);
    ticks(3, 2'b00);
    checkOutput("fly3.m_x", 32'(bus.m_x), 32'd152);

    // Fly to the right edge: 152 + 107*4 = 580
    ticks(107, 2'b00);
    checkOutput("edge580.m_x", 32'(bus.m_x), 32'd580);
    ticks(1, 2'b00);
    checkOutput("edge584.m_x",     32'(bus.m_x),     32'd584);
    checkOutput("edge584.m_valid", 32'(bus.m_valid), 32'd1);
    ticks(1, 2'b00);
    checkOutput("retire.m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("retire.m_x",     32'(bus.m_x),     32'd584);

    // Launch position past the edge is refused; a legal one relaunches
    bus.d_x = 10'd545;
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    checkOutput("nolaunch.m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("nolaunch.m_x",     32'(bus.m_x),     32'd584);
    bus.d_x = 10'd100;
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    checkOutput("relaunch.m_x",     32'(bus.m_x),     32'd140);
    checkOutput("relaunch.m_valid", 32'(bus.m_valid), 32'd1);

    // Robot hit held for many cycles counts once; respawn after 32 ticks
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b01);
    checkOutput("rhit.score",   32'(bus.score),   32'd1);
    checkOutput("rhit.m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("rhit.r_valid", 32'(bus.r_valid), 32'd0);
    ticks(31, 2'b01);
    checkOutput("resp31.r_valid", 32'(bus.r_valid), 32'd0);
    checkOutput("resp31.score",   32'(bus.score),   32'd1);
    ticks(1, 2'b01);
    checkOutput("resp32.r_valid", 32'(bus.r_valid), 32'd1);
    idles(100, 2'b01);
    checkOutput("held.score", 32'(bus.score), 32'd1);

    // Fire together with a new robot hit: no launch, score increments
    idles(1, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b01);
    checkOutput("firehit.score",   32'(bus.score),   32'd2);
    checkOutput("firehit.m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("firehit.r_valid", 32'(bus.r_valid), 32'd0);

    // 01 -> 11 is a new event: dragon dies, enter HIT
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b11);
    checkOutput("dhit.lives",   32'(bus.lives),   32'd2);
    checkOutput("dhit.d_valid", 32'(bus.d_valid), 32'd1);
    ticks(7, 2'b11);
    checkOutput("blink7.d_valid", 32'(bus.d_valid), 32'd1);
    ticks(1, 2'b11);
    checkOutput("blink8.d_valid", 32'(bus.d_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b11);
    checkOutput("hitfire.m_valid", 32'(bus.m_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b11);
    checkOutput("hitstart.lives", 32'(bus.lives), 32'd2);
    ticks(8, 2'b11);
    checkOutput("blink16.d_valid", 32'(bus.d_valid), 32'd1);
    checkOutput("blink16.r_valid", 32'(bus.r_valid), 32'd0);
    ticks(47, 2'b11);
    checkOutput("hit63.d_valid",   32'(bus.d_valid),   32'd0);
    checkOutput("hit63.game_over", 32'(bus.game_over), 32'd0);
    ticks(1, 2'b11);
    checkOutput("hit64.d_valid", 32'(bus.d_valid), 32'd1);
    checkOutput("hit64.r_valid", 32'(bus.r_valid), 32'd1);
    checkOutput("hit64.lives",   32'(bus.lives),   32'd2);

    // Lose the remaining lives
    idles(1, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b10);
    checkOutput("die2.lives", 32'(bus.lives), 32'd1);
    ticks(64, 2'b10);
    idles(1, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b10);
    checkOutput("die3.lives", 32'(bus.lives), 32'd0);
    ticks(63, 2'b10);
    checkOutput("over63.game_over", 32'(bus.game_over), 32'd0);
    ticks(1, 2'b10);
    checkOutput("over.game_over", 32'(bus.game_over), 32'd1);
    checkOutput("over.d_valid",   32'(bus.d_valid),   32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b10);
    checkOutput("overfire.m_valid", 32'(bus.m_valid), 32'd0);

    // Start together with a tick in OVER
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b10);
    checkOutput("restart.lives",     32'(bus.lives),     32'd3);
    checkOutput("restart.score",     32'(bus.score),     32'd0);
    checkOutput("restart.game_over", 32'(bus.game_over), 32'd0);
    checkOutput("restart.d_valid",   32'(bus.d_valid),   32'd1);

    // Tick plus new event: retire without advancing
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b10);
    checkOutput("launch2.m_x", 32'(bus.m_x), 32'd140);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01);
    checkOutput("tickev.m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("tickev.m_x",     32'(bus.m_x),     32'd140);
    checkOutput("tickev.score",   32'(bus.score),   32'd1);

    // Fly to 300, die, then reset in the middle of HIT
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b01);
    ticks(40, 2'b01);
    checkOutput("fly300.m_x", 32'(bus.m_x), 32'd300);
    idles(1, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b10);
    checkOutput("die4.lives",   32'(bus.lives),   32'd2);
    checkOutput("die4.m_valid", 32'(bus.m_valid), 32'd0);
    ticks(5, 2'b10);
    #5 rst = 1'b0;
    #1;
    checkReset("rstnow");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_25Hz);
      #1;
    end
    checkReset("rsthold");
    #5 rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
